// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: A/D/PC datapath, Hack ALU, and ready-based instruction/data memory handshakes.
// Optional idle-loop halt detection is compiled in with `define HACK_CPU_HALT_EN.
module hack_cpu_mc #(
  parameter int DW = 16,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] instruction,
  input  logic          instr_valid,
  input  logic [DW-1:0] inM,
  input  logic          mem_ready,
  output logic [DW-1:0] outM,
  output logic          writeM,
  output logic          readM,
  output logic [AW-1:0] addressM,
  output logic [AW-1:0] pc
`ifdef HACK_CPU_HALT_EN
  ,
  output logic          halted
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_STORE
`ifdef HACK_CPU_HALT_EN
    ,
    S_HALT
`endif
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_a, r_d, r_ir, r_mdr, r_outm;
  logic [AW-1:0] r_pc;
  logic          r_writem, r_readm;
`ifdef HACK_CPU_HALT_EN
  logic          r_halted;
`endif

  logic [DW-1:0] w_x, w_y, w_alu;
  logic          w_zr, w_ng, w_jump, w_commit;
  logic [AW-1:0] w_pc_inc, w_target;

  // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
  always_comb begin
    w_x = r_ir[11] ? '0 : r_d;
    if (r_ir[10]) w_x = ~w_x;
    w_y = r_ir[12] ? r_mdr : r_a;
    if (r_ir[9]) w_y = '0;
    if (r_ir[8]) w_y = ~w_y;
    w_alu = r_ir[7] ? (w_x + w_y) : (w_x & w_y);
    if (r_ir[6]) w_alu = ~w_alu;
  end

  assign w_zr     = (w_alu == '0);
  assign w_ng     = w_alu[DW-1];
  assign w_jump   = (r_ir[2] & w_ng) | (r_ir[1] & w_zr) | (r_ir[0] & ~w_ng & ~w_zr);
  assign w_pc_inc = r_pc + AW'(1);
  assign w_target = r_a[AW-1:0];
  // A store defers the register commit until the memory accepts the write.
  assign w_commit = ((r_state == S_EXEC) && r_ir[DW-1] && !r_ir[3]) ||
                    ((r_state == S_STORE) && mem_ready);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_FETCH;
      r_a      <= '0;
      r_d      <= '0;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_outm   <= '0;
      r_pc     <= '0;
      r_writem <= 1'b0;
      r_readm  <= 1'b0;
`ifdef HACK_CPU_HALT_EN
      r_halted <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (instr_valid) begin
            r_ir <= instruction;
            if (instruction[DW-1] && instruction[12]) begin
              r_state <= S_LOAD;
              r_readm <= 1'b1;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_LOAD: begin
          if (mem_ready) begin
            r_mdr   <= inM;
            r_readm <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!r_ir[DW-1]) begin
            r_a     <= {1'b0, r_ir[DW-2:0]};
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end else if (r_ir[3]) begin
            r_outm   <= w_alu;
            r_writem <= 1'b1;
            r_state  <= S_STORE;
          end else begin
`ifdef HACK_CPU_HALT_EN
            if (w_jump && (w_target == r_pc)) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else
`endif
            r_state <= S_FETCH;
          end
        end
        S_STORE: begin
          if (mem_ready) begin
            r_writem <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
`ifdef HACK_CPU_HALT_EN
        S_HALT: r_state <= S_HALT;
`endif
        default: r_state <= S_FETCH;
      endcase

      if (w_commit) begin
        if (r_ir[5]) r_a <= w_alu;
        if (r_ir[4]) r_d <= w_alu;
        r_pc <= w_jump ? w_target : w_pc_inc;
      end
    end
  end

  assign outM     = r_outm;
  assign writeM   = r_writem;
  assign readM    = r_readm;
  assign addressM = r_a[AW-1:0];
  assign pc       = r_pc;
`ifdef HACK_CPU_HALT_EN
  assign halted   = r_halted;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: directed latency/jump/wrap/reset scenarios plus random programs
// compared against an instruction-level Hack interpreter.
module tb_hack_cpu_mc;
  localparam int DW = 16;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] instruction = '0;
  logic          instr_valid = 1'b0;
  logic [DW-1:0] inM = '0;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] outM;
  logic          writeM, readM;
  logic [AW-1:0] addressM, pc;
`ifdef HACK_CPU_HALT_EN
  logic          halted;
`endif

  hack_cpu_mc #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .instr_valid(instr_valid),
    .inM(inM), .mem_ready(mem_ready), .outM(outM), .writeM(writeM), .readM(readM),
    .addressM(addressM), .pc(pc)
`ifdef HACK_CPU_HALT_EN
    , .halted(halted)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [15:0] I_D_A   = 16'hEC10;  // D=A
  localparam logic [15:0] I_M_D   = 16'hE308;  // M=D
  localparam logic [15:0] I_D_M   = 16'hFC10;  // D=M
  localparam logic [15:0] I_JMP0  = 16'hEA87;  // 0;JMP
  localparam logic [15:0] I_AM_P1 = 16'hEDEF;  // AM=A+1;JMP
  localparam logic [15:0] I_D_N1  = 16'hEE90;  // D=-1
  localparam logic [15:0] I_D_0   = 16'hEA90;  // D=0

  logic [15:0] rom  [0:32767];
  logic [15:0] ram  [0:32767];
  logic [15:0] mram [0:32767];

  int n_cmp = 0;
  int n_bad = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: ready after ready_delay busy cycles
  int ready_delay = 1;
  bit valid_rand = 1'b0;
  int busy_cnt = 0;
  int read_cycles = 0;
  int write_cycles = 0;
  logic [30:0] dut_wq[$], exp_wq[$];
  logic [14:0] dut_rq[$], exp_rq[$];
  logic [15:0] model_a;

  // Memory agent: serves ROM/RAM and logs completed transfers half a cycle before the edge.
  always @(negedge clk) begin
    if (readM || writeM) busy_cnt++;
    else busy_cnt = 0;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ($urandom_range(0, 2) != 0);
      default: mem_ready = (busy_cnt >= ready_delay);
    endcase
    instr_valid = valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    instruction = rom[pc];
    if (readM) read_cycles++;
    if (writeM) write_cycles++;
    if (readM && writeM) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rw_exclusive: readM=%0b writeM=%0b, required not both 1", readM, writeM);
    end
    if (writeM && mem_ready) begin
      dut_wq.push_back({addressM, outM});
      ram[addressM] = outM;
    end
    if (readM && mem_ready) dut_rq.push_back(addressM);
    inM = readM ? ram[addressM] : 16'($urandom);
  end

  function automatic logic [15:0] alu(input logic [15:0] xi, input logic [15:0] yi,
                                      input logic [5:0] c);
    logic [15:0] x, y, o;
    x = c[5] ? 16'h0 : xi;
    x = c[4] ? ~x : x;
    y = c[3] ? 16'h0 : yi;
    y = c[2] ? ~y : y;
    o = c[1] ? 16'(x + y) : (x & y);
    return c[0] ? ~o : o;
  endfunction

  // Instruction-level interpreter; stops when pc reaches the terminal loop.
  task automatic run_model(input int n_end);
    logic [15:0] a, d, ins, y, r;
    int p, steps;
    bit taken;
    a = '0; d = '0; p = 0; steps = 0;
    mram = ram;
    exp_wq.delete();
    exp_rq.delete();
    while (p != n_end && steps < 2000) begin
      ins = rom[p];
      steps++;
      if (!ins[15]) begin
        a = ins;
        p = (p + 1) % 32768;
      end else begin
        if (ins[12]) exp_rq.push_back(a[14:0]);
        y = ins[12] ? mram[a[14:0]] : a;
        r = alu(d, y, ins[11:6]);
        if (ins[3]) begin
          exp_wq.push_back({a[14:0], r});
          mram[a[14:0]] = r;
        end
        taken = (ins[2] && $signed(r) < 0) || (ins[1] && r == 0) || (ins[0] && $signed(r) > 0);
        p = taken ? int'(a[14:0]) : (p + 1) % 32768;
        if (ins[5]) a = r;
        if (ins[4]) d = r;
      end
    end
    model_a = a;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    dut_wq.delete();
    dut_rq.delete();
    read_cycles = 0;
    write_cycles = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [14:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (pc === target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_cmp++;
    if ({pc, addressM, outM, writeM, readM} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: pc=%h addr=%h outM=%h w=%b r=%b, required all 0",
               pc, addressM, outM, writeM, readM);
    end
  endtask

  task automatic test_store_latency();
    clear_rom();
    rom[0] = 16'd21; rom[1] = I_D_A; rom[2] = I_M_D; rom[3] = 16'd3; rom[4] = I_JMP0;
    ready_mode = 0; valid_rand = 0;
    do_reset();
    clocks(4);
    n_cmp++;
    if (pc !== 15'd2) begin n_bad++; $display("FAIL lat_pc4: pc=%0d, required 2", pc); end
    clocks(3);
    n_cmp++;
    if (pc !== 15'd3) begin n_bad++; $display("FAIL lat_pc7: pc=%0d, required 3", pc); end
    n_cmp++;
    if (write_cycles !== 1 || read_cycles !== 0) begin
      n_bad++;
      $display("FAIL lat_pulses: writes=%0d reads=%0d, required 1/0", write_cycles, read_cycles);
    end
    n_cmp++;
    if (dut_wq.size() !== 1 || dut_wq[0] !== {15'd21, 16'd21}) begin
      n_bad++;
      $display("FAIL lat_store: n=%0d first=%h, required 1 entry %h", dut_wq.size(),
               dut_wq.size() > 0 ? dut_wq[0] : 31'h0, {15'd21, 16'd21});
    end
  endtask

  task automatic test_load_wait();
    bit ok;
    clear_rom();
    ram[5] = 16'h1234;
    rom[0] = 16'd5; rom[1] = I_D_M; rom[2] = 16'd9; rom[3] = I_M_D; rom[4] = 16'd4;
    rom[5] = I_JMP0;
    ready_mode = 2; ready_delay = 3; valid_rand = 0;
    do_reset();
    clocks(7);
    n_cmp++;
    if (pc !== 15'd2 || read_cycles !== 3 || write_cycles !== 0) begin
      n_bad++;
      $display("FAIL load_wait: pc=%0d reads=%0d writes=%0d, required 2/3/0",
               pc, read_cycles, write_cycles);
    end
    wait_pc(15'd4, 100, ok);
    n_cmp++;
    if (!ok || dut_wq.size() !== 1 || dut_wq[0] !== {15'd9, 16'h1234}) begin
      n_bad++;
      $display("FAIL load_data: reached=%0b n=%0d first=%h, required %h", ok, dut_wq.size(),
               dut_wq.size() > 0 ? dut_wq[0] : 31'h0, {15'd9, 16'h1234});
    end
  endtask

  task automatic test_store_jump();
    clear_rom();
    rom[0] = 16'h0100; rom[1] = I_AM_P1; rom[256] = 16'h0100; rom[257] = I_JMP0;
    ready_mode = 0; valid_rand = 0;
    do_reset();
    clocks(5);
    n_cmp++;
    if (pc !== 15'h100 || addressM !== 15'h101) begin
      n_bad++;
      $display("FAIL store_jump: pc=%h A=%h, required 100/101", pc, addressM);
    end
    n_cmp++;
    if (dut_wq.size() !== 1 || dut_wq[0] !== {15'h100, 16'h0101}) begin
      n_bad++;
      $display("FAIL store_jump_wr: n=%0d first=%h, required %h", dut_wq.size(),
               dut_wq.size() > 0 ? dut_wq[0] : 31'h0, {15'h100, 16'h0101});
    end
  endtask

  task automatic test_jumps();
    int dv;
    bit taken;
    logic [14:0] exp_pc;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        dv = (k == 0) ? -1 : 0;
        clear_rom();
        rom[0] = (k == 0) ? I_D_N1 : I_D_0;
        rom[1] = 16'd7;
        rom[2] = 16'hE300 | (16'h4 >> j);
        rom[3] = 16'd3; rom[4] = I_JMP0; rom[7] = 16'd7; rom[8] = I_JMP0;
        taken = (j == 0) ? (dv < 0) : (j == 1) ? (dv == 0) : (dv > 0);
        exp_pc = taken ? 15'd7 : 15'd3;
        ready_mode = 0; valid_rand = 0;
        do_reset();
        clocks(6);
        n_cmp++;
        if (pc !== exp_pc) begin
          n_bad++;
          $display("FAIL jump_d%0d_j%0d: pc=%0d, required %0d", dv, j, pc, exp_pc);
        end
      end
    end
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[0] = 16'h7FFF; rom[1] = I_JMP0; rom[32767] = 16'd5;
    ready_mode = 0; valid_rand = 0;
    do_reset();
    clocks(4);
    n_cmp++;
    if (pc !== 15'h7FFF) begin n_bad++; $display("FAIL wrap_top: pc=%h, required 7fff", pc); end
    clocks(2);
    n_cmp++;
    if (pc !== 15'd0 || addressM !== 15'd5) begin
      n_bad++;
      $display("FAIL wrap_zero: pc=%h A=%h, required 0/5", pc, addressM);
    end
  endtask

  task automatic test_reset_mid_store();
    bit seen;
    clear_rom();
    rom[0] = 16'd21; rom[1] = I_D_A; rom[2] = I_M_D; rom[3] = 16'd3; rom[4] = I_JMP0;
    ready_mode = 2; ready_delay = 1000; valid_rand = 0;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = writeM;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL mid_store_wait: writeM=0, required 1 within 40 clk"); end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (writeM !== 1'b0 || pc !== 15'd0 || addressM !== 15'd0) begin
      n_bad++;
      $display("FAIL mid_store_abort: w=%b pc=%h A=%h, required 0/0/0", writeM, pc, addressM);
    end
    clear_rom();
    rom[0] = 16'd9; rom[1] = I_M_D; rom[2] = 16'd2; rom[3] = I_JMP0;
    ready_mode = 0;
    do_reset();
    clocks(6);
    n_cmp++;
    if (dut_wq.size() !== 1 || dut_wq[0] !== {15'd9, 16'd0}) begin
      n_bad++;
      $display("FAIL mid_store_d0: n=%0d first=%h, required %h", dut_wq.size(),
               dut_wq.size() > 0 ? dut_wq[0] : 31'h0, {15'd9, 16'd0});
    end
  endtask

  task automatic test_random_programs();
    int pairs, n_end, tgt;
    logic [15:0] c;
    bit ok;
    for (int t = 0; t < 10; t++) begin
      clear_rom();
      for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
      pairs = $urandom_range(6, 14);
      n_end = 2 * pairs + 2;
      for (int i = 0; i < pairs; i++) begin
        c = {3'b111, 1'($urandom_range(0, 1)), 6'($urandom), 3'($urandom), 3'b000};
        if ($urandom_range(0, 2) == 0) begin
          tgt = 2 * $urandom_range(i + 1, pairs + 1);
          rom[2*i] = 16'(tgt);
          c[2:0] = 3'($urandom_range(1, 7));
        end else begin
          rom[2*i] = 16'($urandom_range(0, 31));
        end
        rom[2*i+1] = c;
      end
      rom[2*pairs] = 16'd200; rom[2*pairs+1] = I_M_D;
      rom[n_end] = 16'(n_end); rom[n_end+1] = I_JMP0;
      run_model(n_end);
      ready_mode = 1; valid_rand = 1;
      do_reset();
      wait_pc(15'(n_end), 5000, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL rand%0d_timeout: pc=%0d, required %0d", t, pc, n_end); end
      n_cmp++;
      if (dut_wq.size() !== exp_wq.size() || dut_rq.size() !== exp_rq.size()) begin
        n_bad++;
        $display("FAIL rand%0d_counts: writes=%0d reads=%0d, required %0d/%0d", t,
                 dut_wq.size(), dut_rq.size(), exp_wq.size(), exp_rq.size());
      end
      for (int i = 0; i < exp_wq.size() && i < dut_wq.size(); i++) begin
        n_cmp++;
        if (dut_wq[i] !== exp_wq[i]) begin
          n_bad++;
          $display("FAIL rand%0d_wr%0d: got %h, required %h", t, i, dut_wq[i], exp_wq[i]);
        end
      end
      for (int i = 0; i < exp_rq.size() && i < dut_rq.size(); i++) begin
        n_cmp++;
        if (dut_rq[i] !== exp_rq[i]) begin
          n_bad++;
          $display("FAIL rand%0d_rd%0d: got %h, required %h", t, i, dut_rq[i], exp_rq[i]);
        end
      end
      n_cmp++;
      if (addressM !== model_a[14:0]) begin
        n_bad++;
        $display("FAIL rand%0d_areg: A=%h, required %h", t, addressM, model_a[14:0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 16'($urandom);
    clear_rom();
    test_reset();
    test_store_latency();
    test_load_wait();
    test_store_jump();
    test_jumps();
    test_wrap();
    test_reset_mid_store();
    test_random_programs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
